// File: rtl/s_axi_burst_wr.sv
// AXI3 write-channel responder (AW/W/B) that stores burst beats into a small register bank.
// Define S_AXI_WID_CHECK_EN to reject any beat whose wid_i differs from the latched awid.
module s_axi_burst_wr #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    MEM_DEPTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                         clk,
  input  logic                         areset,
  input  logic [3:0]                   awid_i,
  input  logic [ADDR_WIDTH-1:0]        awaddr_i,
  input  logic [3:0]                   awlen_i,
  input  logic [2:0]                   awsize_i,
  input  logic [1:0]                   awburst_i,
  input  logic                         awvalid_i,
  output logic                         awready_o,
  input  logic [3:0]                   wid_i,
  input  logic [DATA_WIDTH-1:0]        wdata_i,
  input  logic [DATA_WIDTH/8-1:0]      wstrb_i,
  input  logic                         wlast_i,
  input  logic                         wvalid_i,
  output logic                         wready_o,
  output logic [3:0]                   bid_o,
  output logic [1:0]                   bresp_o,
  output logic                         bvalid_o,
  input  logic                         bready_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] rd_idx_i,
  output logic [DATA_WIDTH-1:0]        rd_data_o,
  output logic                         burst_done_o
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int SH = $clog2(NB);
  localparam int IW = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic                    alive_q;
  logic [3:0]              id_q, len_q, cnt_q;
  logic [1:0]              burst_q;
  logic [ADDR_WIDTH-1:0]   addr_q, next_addr, idx_full, wrap_mask, incr_addr;
  logic                    over_q, cfg_err_q, slv_q, dec_q;
  logic                    aw_hs, w_hs, cfg_err, beat_dec, beat_slv, beat_we, wid_err;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  assign aw_hs = awvalid_i && alive_q && (state_q == S_IDLE);
  assign w_hs  = wvalid_i && (state_q == S_DATA);

  assign cfg_err = (awsize_i != 3'(SH)) || (awburst_i == 2'b11) ||
                   ((awburst_i == 2'b10) && !(awlen_i inside {4'd1, 4'd3, 4'd7, 4'd15}));

`ifdef S_AXI_WID_CHECK_EN
  assign wid_err = (wid_i != id_q);
`else
  logic unused_wid;
  assign unused_wid = ^wid_i;
  assign wid_err    = 1'b0;
`endif

  // Beat classification: out-of-bank addresses decode-fail; framing and ID errors are slave errors.
  assign idx_full = (addr_q - BASE_ADDR) >> SH;
  assign beat_dec = (addr_q < BASE_ADDR) || (idx_full >= ADDR_WIDTH'(MEM_DEPTH));
  assign beat_slv = over_q || (wlast_i && (cnt_q != len_q)) || wid_err;
  assign beat_we  = w_hs && !cfg_err_q && !beat_dec && !beat_slv;

  assign incr_addr = addr_q + ADDR_WIDTH'(NB);
  assign wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << SH) - ADDR_WIDTH'(1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    next_addr = incr_addr;
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = incr_addr;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    awready_o    = 1'b0;
    wready_o     = 1'b0;
    bvalid_o     = 1'b0;
    bid_o        = '0;
    bresp_o      = 2'b00;
    burst_done_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        awready_o = alive_q;
        if (aw_hs) state_d = S_DATA;
      end
      S_DATA: begin
        wready_o = 1'b1;
        if (w_hs && wlast_i) state_d = S_RESP;
      end
      S_RESP: begin
        bvalid_o = 1'b1;
        bid_o    = id_q;
        bresp_o  = dec_q ? 2'b11 : (slv_q ? 2'b10 : 2'b00);
        if (bready_i) begin
          burst_done_o = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // alive_q keeps awready_o low while reset is held and rises on the first edge after release.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      alive_q   <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      over_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      slv_q     <= 1'b0;
      dec_q     <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      if (aw_hs) begin
        id_q      <= awid_i;
        addr_q    <= awaddr_i & ~ADDR_WIDTH'(NB - 1);
        len_q     <= awlen_i;
        burst_q   <= awburst_i;
        cnt_q     <= '0;
        over_q    <= 1'b0;
        cfg_err_q <= cfg_err;
        slv_q     <= cfg_err;
        dec_q     <= 1'b0;
      end else if (w_hs) begin
        addr_q <= next_addr;
        cnt_q  <= cnt_q + 4'd1;
        if ((cnt_q == len_q) && !wlast_i) over_q <= 1'b1;
        dec_q  <= dec_q | beat_dec;
        slv_q  <= slv_q | beat_slv;
      end
    end
  end

  // NOTE: the bank is a register file, not RAM, so it can and must be cleared by the async reset.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (beat_we) begin
      for (int b = 0; b < NB; b++)
        if (wstrb_i[b]) mem[idx_full[IW-1:0]][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rd_data_o = ({1'b0, rd_idx_i} < (IW+1)'(MEM_DEPTH)) ? mem[rd_idx_i] : '0;

endmodule

// File: tb/tb_s_axi_burst_wr.sv
// Scoreboard bench for s_axi_burst_wr: expected B responses are queued as bursts are issued,
// and the bank is compared against a reference image after each scenario.
module tb_s_axi_burst_wr;

  localparam int DW    = 32;
  localparam int AW    = 64;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          areset;
  logic [3:0]    awid, awlen, wid, bid;
  logic [AW-1:0] awaddr;
  logic [2:0]    awsize, rd_idx;
  logic [1:0]    awburst, bresp;
  logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready, burst_done;
  logic [DW-1:0] wdata, rd_data;
  logic [3:0]    wstrb;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  bexp_t       b_q[$];
  logic [31:0] exp_mem [DEPTH];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  s_axi_burst_wr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .BASE_ADDR('0)) dut (
    .clk(clk), .areset(areset),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize), .awburst_i(awburst),
    .awvalid_i(awvalid), .awready_o(awready),
    .wid_i(wid), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid),
    .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .rd_idx_i(rd_idx), .rd_data_o(rd_data), .burst_done_o(burst_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [63:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    b_q.push_back('{id: id, resp: resp});
    while (awready !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (awready !== 1'b1) begin
      failures++; $display("FAIL aw_timeout awready=%b required=1", awready);
    end
    tick();
    awvalid = 1'b0;
    checks++;
    if (wready !== 1'b1) begin
      failures++; $display("FAIL aw_to_w_latency wready=%b required=1", wready);
    end
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last,
                        input logic [3:0] id);
    int n = 0;
    wdata = data; wstrb = strb; wlast = last; wid = id; wvalid = 1'b1;
    while (wready !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (wready !== 1'b1) begin
      failures++; $display("FAIL w_timeout wready=%b required=1", wready);
    end
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    if (last) begin
      checks++;
      if (bvalid !== 1'b1) begin
        failures++; $display("FAIL w_to_b_latency bvalid=%b required=1", bvalid);
      end
    end
  endtask

  task automatic collect_b(input int hold);
    bexp_t e = '0;
    int    n = 0;
    while (bvalid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (bvalid !== 1'b1) begin
      failures++; $display("FAIL b_timeout bvalid=%b required=1", bvalid);
    end
    checks++;
    if (b_q.size() == 0) begin
      failures++; $display("FAIL b_unexpected queue_size=0 required=1");
    end else e = b_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      checks++;
      if ({bvalid, bid, bresp, awready, burst_done} !== {1'b1, e.id, e.resp, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL b_hold cyc=%0d got v=%b id=%h resp=%b awr=%b done=%b required v=1 id=%h resp=%b awr=0 done=0",
                 i, bvalid, bid, bresp, awready, burst_done, e.id, e.resp);
      end
      tick();
    end
    bready = 1'b1;
    #1;
    checks++;
    if (bid !== e.id) begin failures++; $display("FAIL bid got=%h required=%h", bid, e.id); end
    checks++;
    if (bresp !== e.resp) begin failures++; $display("FAIL bresp got=%b required=%b", bresp, e.resp); end
    checks++;
    if (burst_done !== 1'b1) begin failures++; $display("FAIL burst_done got=%b required=1", burst_done); end
    tick();
    bready = 1'b0;
    checks++;
    if (awready !== 1'b1 || bvalid !== 1'b0) begin
      failures++; $display("FAIL b_to_aw_latency awready=%b bvalid=%b required=1/0", awready, bvalid);
    end
  endtask

  task automatic test_reset();
    areset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({awready, wready, bvalid, bid, bresp, burst_done} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs got awr=%b wr=%b bv=%b bid=%h bresp=%b done=%b required all 0",
               awready, wready, bvalid, bid, bresp, burst_done);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = 3'(i); #1; checks++;
      if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_mem[%0d] got=%h required=0", i, rd_data); end
    end
    areset = 1'b1;
    tick();
    checks++;
    if (awready !== 1'b1) begin failures++; $display("FAIL reset_release awready=%b required=1", awready); end
  endtask

  task automatic test_incr();
    send_aw(4'd3, 64'h0, 4'd7, 3'd2, 2'b01, 2'b00);
    for (int i = 0; i < 8; i++) begin
      send_w(32'((i + 1) * 17), 4'hF, i == 7, 4'd3);
      exp_mem[i] = 32'((i + 1) * 17);
    end
    collect_b(0);
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = 3'(i); #1; checks++;
      if (rd_data !== exp_mem[i]) begin failures++; $display("FAIL incr_mem[%0d] got=%h required=%h", i, rd_data, exp_mem[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d [4] = '{32'hAAAA_000A, 32'hBBBB_000B, 32'hCCCC_000C, 32'h00DD_000D};
    send_aw(4'd5, 64'h0C, 4'd3, 3'd2, 2'b10, 2'b00);
    for (int i = 0; i < 4; i++) send_w(d[i], 4'hF, i == 3, 4'd5);
    collect_b(0);
    exp_mem[3] = d[0]; exp_mem[0] = d[1]; exp_mem[1] = d[2]; exp_mem[2] = d[3];
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = 3'(i); #1; checks++;
      if (rd_data !== exp_mem[i]) begin failures++; $display("FAIL wrap_mem[%0d] got=%h required=%h", i, rd_data, exp_mem[i]); end
    end
  endtask

  task automatic test_fixed();
    send_aw(4'd2, 64'h08, 4'd2, 3'd2, 2'b00, 2'b00);
    send_w(32'hFFFF_FFFF, 4'h1, 1'b0, 4'd2);
    send_w(32'hFFFF_FFFF, 4'h2, 1'b0, 4'd2);
    send_w(32'hFFFF_FFFF, 4'h4, 1'b1, 4'd2);
    collect_b(0);
    exp_mem[2] = {exp_mem[2][31:24], 24'hFF_FFFF};
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = 3'(i); #1; checks++;
      if (rd_data !== exp_mem[i]) begin failures++; $display("FAIL fixed_mem[%0d] got=%h required=%h", i, rd_data, exp_mem[i]); end
    end
  endtask

  task automatic test_errors();
    // Decode error: beat 1 runs past the bank.
    send_aw(4'd6, 64'h1C, 4'd1, 3'd2, 2'b01, 2'b11);
    send_w(32'h7777_0007, 4'hF, 1'b0, 4'd6);
    send_w(32'h8888_0008, 4'hF, 1'b1, 4'd6);
    collect_b(0);
    exp_mem[7] = 32'h7777_0007;
    // Early wlast on beat 1 of a 4-beat burst: that beat is not written.
    send_aw(4'd7, 64'h0, 4'd3, 3'd2, 2'b01, 2'b10);
    send_w(32'h1234_5678, 4'hF, 1'b0, 4'd7);
    send_w(32'h9999_9999, 4'hF, 1'b1, 4'd7);
    collect_b(0);
    exp_mem[0] = 32'h1234_5678;
    // Extra beat past len without wlast: accepted, dropped.
    send_aw(4'd8, 64'h10, 4'd0, 3'd2, 2'b01, 2'b10);
    send_w(32'h4444_4444, 4'hF, 1'b0, 4'd8);
    send_w(32'h5555_5555, 4'hF, 1'b1, 4'd8);
    collect_b(0);
    exp_mem[4] = 32'h4444_4444;
    // Illegal configurations: nothing written.
    send_aw(4'd10, 64'h18, 4'd0, 3'd1, 2'b01, 2'b10);
    send_w(32'hBAD0_0001, 4'hF, 1'b1, 4'd10);
    collect_b(0);
    send_aw(4'd11, 64'h0, 4'd2, 3'd2, 2'b10, 2'b10);
    for (int i = 0; i < 3; i++) send_w(32'hBAD0_0002, 4'hF, i == 2, 4'd11);
    collect_b(0);
    send_aw(4'd12, 64'h18, 4'd0, 3'd2, 2'b11, 2'b10);
    send_w(32'hBAD0_0003, 4'hF, 1'b1, 4'd12);
    collect_b(0);
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = 3'(i); #1; checks++;
      if (rd_data !== exp_mem[i]) begin failures++; $display("FAIL err_mem[%0d] got=%h required=%h", i, rd_data, exp_mem[i]); end
    end
  endtask

  task automatic test_backpressure();
    send_aw(4'd9, 64'h18, 4'd0, 3'd2, 2'b01, 2'b00);
    send_w(32'h6060_6060, 4'hF, 1'b1, 4'd9);
    collect_b(5);
    exp_mem[6] = 32'h6060_6060;
    rd_idx = 3'd6; #1; checks++;
    if (rd_data !== exp_mem[6]) begin failures++; $display("FAIL bp_mem got=%h required=%h", rd_data, exp_mem[6]); end
  endtask

  task automatic test_wid();
`ifdef S_AXI_WID_CHECK_EN
    send_aw(4'd1, 64'h14, 4'd0, 3'd2, 2'b01, 2'b10);
`else
    send_aw(4'd1, 64'h14, 4'd0, 3'd2, 2'b01, 2'b00);
    exp_mem[5] = 32'h5A5A_5A5A;
`endif
    send_w(32'h5A5A_5A5A, 4'hF, 1'b1, 4'd2);
    collect_b(0);
    rd_idx = 3'd5; #1; checks++;
    if (rd_data !== exp_mem[5]) begin failures++; $display("FAIL wid_mem got=%h required=%h", rd_data, exp_mem[5]); end
  endtask

  task automatic test_reset_mid_burst();
    send_aw(4'd4, 64'h0, 4'd3, 3'd2, 2'b01, 2'b00);
    send_w(32'hDEAD_0000, 4'hF, 1'b0, 4'd4);
    areset = 1'b0;
    #1;
    b_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
    checks++;
    if ({awready, wready, bvalid} !== 3'b000) begin
      failures++; $display("FAIL midrst_outputs awr=%b wr=%b bv=%b required 000", awready, wready, bvalid);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = 3'(i); #1; checks++;
      if (rd_data !== 32'h0) begin failures++; $display("FAIL midrst_mem[%0d] got=%h required=0", i, rd_data); end
    end
    tick();
    areset = 1'b1;
    tick();
    checks++;
    if (awready !== 1'b1 || bvalid !== 1'b0) begin
      failures++; $display("FAIL midrst_release awready=%b bvalid=%b required=1/0", awready, bvalid);
    end
  endtask

  task automatic test_back_to_back();
    send_aw(4'd13, 64'h0, 4'd1, 3'd2, 2'b01, 2'b00);
    send_w(32'h0000_0001, 4'hF, 1'b0, 4'd13);
    send_w(32'h0000_0002, 4'hF, 1'b1, 4'd13);
    collect_b(0);
    send_aw(4'd14, 64'h8, 4'd0, 3'd2, 2'b01, 2'b00);
    send_w(32'h0000_0003, 4'hF, 1'b1, 4'd14);
    collect_b(0);
    exp_mem[0] = 32'h1; exp_mem[1] = 32'h2; exp_mem[2] = 32'h3;
    for (int i = 0; i < DEPTH; i++) begin
      rd_idx = 3'(i); #1; checks++;
      if (rd_data !== exp_mem[i]) begin failures++; $display("FAIL b2b_mem[%0d] got=%h required=%h", i, rd_data, exp_mem[i]); end
    end
    checks++;
    if (b_q.size() != 0) begin failures++; $display("FAIL b_leftover queue_size=%0d required=0", b_q.size()); end
  endtask

  initial begin
    areset = 1'b0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rd_idx = '0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h0;
    test_reset();
    test_incr();
    test_wrap();
    test_fixed();
    test_errors();
    test_backpressure();
    test_wid();
    test_reset_mid_burst();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
